fifo_rd_ptr_ctrl: RTL and testbench

FIFO_RD_PTR_CTRL -- requirements
Module: fifo_rd_ptr_ctrl

---
 rtl/fifo_rd_ptr_ctrl.sv | 90 +++++++++
 tb/tb_fifo_rd_ptr_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer controller for an asynchronous FIFO: synchronizes the Gray
// write pointer and produces the Gray read pointer, read address and status flags.
module fifo_rd_ptr_ctrl #(
    parameter int ADD_WIDTH     = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 rd_inc,
    input  logic [ADD_WIDTH:0]   wr_ptr,
    input  logic                 rd_err_clr,
    output logic [ADD_WIDTH:0]   rd_ptr,
    output logic [ADD_WIDTH-1:0] rd_addr,
    output logic                 rd_empty,
    output logic                 rd_aempty,
    output logic [ADD_WIDTH:0]   rd_level,
    output logic                 rd_underflow
);

    localparam int PW = ADD_WIDTH + 1;
    localparam logic [PW-1:0] AEMPTY_LIM = PW'(AEMPTY_THRESH);

    logic [PW-1:0] wq1;
    logic [PW-1:0] wq2;
    logic [PW-1:0] wr_bin_sync;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_gray;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray_next;
    logic [PW-1:0] rd_level_next;
    logic          rd_accept;

    // Two-flop synchronizer; the stages are back-to-back with no logic between.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            wq1 <= wr_ptr;
            wq2 <= wq1;
        end
    end

    // Each binary bit is the XOR of the Gray bit at that position and all above it.
    always_comb begin
        wr_bin_sync = '0;
        for (int i = 0; i < PW; i++) begin
            wr_bin_sync[i] = ^(wq2 >> i);
        end
    end

    always_comb begin
        rd_accept     = rd_inc & ~rd_empty;
        rd_bin_next   = rd_bin + PW'(rd_accept);
        rd_gray_next  = rd_bin_next ^ (rd_bin_next >> 1);
        rd_level_next = wr_bin_sync - rd_bin_next;
    end

    // Flags are computed from the post-read pointer so a draining read shows empty at once.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_bin    <= '0;
            rd_gray   <= '0;
            rd_empty  <= 1'b1;
            rd_aempty <= 1'b1;
            rd_level  <= '0;
        end else begin
            rd_bin    <= rd_bin_next;
            rd_gray   <= rd_gray_next;
            rd_empty  <= (rd_gray_next == wq2);
            rd_aempty <= (rd_level_next <= AEMPTY_LIM);
            rd_level  <= rd_level_next;
        end
    end

    // A new underflow outranks a clear arriving in the same cycle.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_underflow <= 1'b0;
        end else if (rd_inc && rd_empty) begin
            rd_underflow <= 1'b1;
        end else if (rd_err_clr) begin
            rd_underflow <= 1'b0;
        end
    end

    assign rd_ptr  = rd_gray;
    assign rd_addr = rd_bin[ADD_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Directed bench for fifo_rd_ptr_ctrl at ADD_WIDTH=4, AEMPTY_THRESH=2.
module tb_fifo_rd_ptr_ctrl;

    logic       rd_clk = 1'b0;
    logic       rd_rst;
    logic       rd_inc;
    logic [4:0] wr_ptr;
    logic       rd_err_clr;
    logic [4:0] rd_ptr;
    logic [3:0] rd_addr;
    logic       rd_empty;
    logic       rd_aempty;
    logic [4:0] rd_level;
    logic       rd_underflow;

    int errors = 0;
    int checks = 0;

    fifo_rd_ptr_ctrl #(.ADD_WIDTH(4), .AEMPTY_THRESH(2)) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .rd_inc       (rd_inc),
        .wr_ptr       (wr_ptr),
        .rd_err_clr   (rd_err_clr),
        .rd_ptr       (rd_ptr),
        .rd_addr      (rd_addr),
        .rd_empty     (rd_empty),
        .rd_aempty    (rd_aempty),
        .rd_level     (rd_level),
        .rd_underflow (rd_underflow)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    function automatic logic [4:0] gray(input int unsigned b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic do_reset();
        rd_rst = 1'b1;
        tick();
        rd_rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({rd_ptr, rd_addr, rd_empty, rd_aempty, rd_level, rd_underflow} !==
            {5'b00000, 4'd0, 1'b1, 1'b1, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL %s: ptr=%b addr=%0d empty=%b aempty=%b level=%0d uf=%b, need ptr=00000 addr=0 empty=1 aempty=1 level=0 uf=0",
                     tag, rd_ptr, rd_addr, rd_empty, rd_aempty, rd_level, rd_underflow);
        end
    endtask

    task automatic test_reset();
        rd_inc = 1'b0; rd_err_clr = 1'b0; wr_ptr = 5'b00000;
        do_reset();
        check_reset_outputs("reset");
    endtask

    task automatic test_fill_drain();
        do_reset();
        wr_ptr = 5'b00010;
        tick();
        tick();
        checks++;
        if (rd_empty !== 1'b1) begin
            errors++;
            $display("FAIL sync_latency: empty=%b after 2 edges, need 1", rd_empty);
        end
        tick();
        checks++;
        if (rd_empty !== 1'b0 || rd_level !== 5'd3 || rd_aempty !== 1'b0) begin
            errors++;
            $display("FAIL fill: empty=%b level=%0d aempty=%b, need 0 3 0", rd_empty, rd_level, rd_aempty);
        end
        rd_inc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_addr !== 4'(i)) begin
                errors++;
                $display("FAIL drain_addr%0d: addr=%0d, need %0d", i, rd_addr, i);
            end
            tick();
            checks++;
            if (rd_level !== 5'(2 - i) || rd_empty !== (i == 2) || rd_aempty !== 1'b1) begin
                errors++;
                $display("FAIL drain%0d: level=%0d empty=%b aempty=%b, need %0d %b 1",
                         i, rd_level, rd_empty, rd_aempty, 2 - i, (i == 2));
            end
        end
        rd_inc = 1'b0;
    endtask

    task automatic test_underflow();
        // Continues from the drained state: rd_bin=3, empty.
        rd_inc = 1'b1;
        tick();
        rd_inc = 1'b0;
        checks++;
        if (rd_ptr !== 5'b00010 || rd_addr !== 4'd3 || rd_underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_set: ptr=%b addr=%0d uf=%b, need 00010 3 1", rd_ptr, rd_addr, rd_underflow);
        end
        tick();
        checks++;
        if (rd_underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky: uf=%b, need 1", rd_underflow);
        end
        rd_err_clr = 1'b1;
        tick();
        rd_err_clr = 1'b0;
        checks++;
        if (rd_underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clr: uf=%b, need 0", rd_underflow);
        end
        rd_inc = 1'b1; rd_err_clr = 1'b1;
        tick();
        rd_inc = 1'b0; rd_err_clr = 1'b0;
        checks++;
        if (rd_underflow !== 1'b1 || rd_ptr !== 5'b00010) begin
            errors++;
            $display("FAIL underflow_set_wins: uf=%b ptr=%b, need 1 00010", rd_underflow, rd_ptr);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        wr_ptr = gray(3);
        repeat (3) tick();
        wr_ptr = gray(5);
        rd_inc = 1'b1;
        tick();
        rd_inc = 1'b0;
        checks++;
        if (rd_level !== 5'd2) begin
            errors++;
            $display("FAIL simul_read: level=%0d, need 2", rd_level);
        end
        tick();
        tick();
        checks++;
        if (rd_level !== 5'd4 || rd_empty !== 1'b0 || rd_aempty !== 1'b0) begin
            errors++;
            $display("FAIL simul_merge: level=%0d empty=%b aempty=%b, need 4 0 0", rd_level, rd_empty, rd_aempty);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] prev;
        do_reset();
        for (int i = 1; i <= 32; i++) begin
            wr_ptr = gray(i);
            repeat (3) tick();
            prev = rd_ptr;
            rd_inc = 1'b1;
            tick();
            rd_inc = 1'b0;
            checks++;
            if (rd_ptr !== gray(i) || $countones(prev ^ rd_ptr) != 1 || rd_addr !== 4'(i)) begin
                errors++;
                $display("FAIL wrap_step%0d: ptr=%b (was %b) addr=%0d, need %b addr=%0d",
                         i, rd_ptr, prev, rd_addr, gray(i), i % 16);
            end
            if (i == 31) begin
                checks++;
                if (rd_ptr !== 5'b10000 || rd_addr !== 4'd15) begin
                    errors++;
                    $display("FAIL wrap_top: ptr=%b addr=%0d, need 10000 15", rd_ptr, rd_addr);
                end
            end
        end
        checks++;
        if (rd_ptr !== 5'b00000 || rd_addr !== 4'd0 || rd_empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_roll: ptr=%b addr=%0d empty=%b, need 00000 0 1", rd_ptr, rd_addr, rd_empty);
        end
    endtask

    task automatic test_full();
        do_reset();
        wr_ptr = 5'b11000;
        repeat (3) tick();
        checks++;
        if (rd_level !== 5'd16 || rd_empty !== 1'b0 || rd_aempty !== 1'b0) begin
            errors++;
            $display("FAIL full: level=%0d empty=%b aempty=%b, need 16 0 0", rd_level, rd_empty, rd_aempty);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        wr_ptr = 5'b00111;
        repeat (3) tick();
        checks++;
        if (rd_level !== 5'd5 || rd_aempty !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: level=%0d aempty=%b, need 5 0", rd_level, rd_aempty);
        end
        rd_inc = 1'b1; rd_rst = 1'b1;
        tick();
        check_reset_outputs("midrst_reset");
        rd_inc = 1'b0; rd_rst = 1'b0;
        tick();
        tick();
        checks++;
        if (rd_level !== 5'd0 || rd_empty !== 1'b1) begin
            errors++;
            $display("FAIL midrst_latency: level=%0d empty=%b, need 0 1", rd_level, rd_empty);
        end
        tick();
        checks++;
        if (rd_level !== 5'd5 || rd_empty !== 1'b0 || rd_aempty !== 1'b0) begin
            errors++;
            $display("FAIL midrst_rebuild: level=%0d empty=%b aempty=%b, need 5 0 0", rd_level, rd_empty, rd_aempty);
        end
    endtask

    initial begin
        rd_rst = 1'b1; rd_inc = 1'b0; rd_err_clr = 1'b0; wr_ptr = '0;
        test_reset();
        test_fill_drain();
        test_underflow();
        test_simultaneous();
        test_wrap();
        test_full();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
